ex_result_arb: RTL and testbench
================================

# ex_result_arb

EX-stage result arbiter that shares the single 10:1 result mux (sel-driven, outputs zero on unused codes) between up to ten result sources. It collects requests from the sources, selects one winner per transaction, drives the mux select code and a valid/ready handshake toward writeback, and returns a one-cycle grant to the winning source. It sits between the EX functional units and the writeback register of the pipeline.

## Interface
- NUM_SRC, 10, number of result sources (2..10); source i maps to mux input i.
- STALL_LIMIT, 15, consecutive wb_ready-low cycles in DRIVE before stall_err sets (1..255).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_SRC  per-source result request; held high until granted.
- gnt  out  NUM_SRC  one-hot grant, high only in the handshake cycle.
- flush  in  1  synchronous pipeline flush.
- wb_ready  in  1  writeback accepts the mux output this cycle.
- wb_valid  out  1  mux output is valid for writeback.
- mux_sel  out  4  select code to the result mux.
- wb_src  out  4  index of the current winner (0..NUM_SRC-1).
- stall_err  out  1  sticky: writeback stalled beyond STALL_LIMIT.

## Operation
- Code mapping: source i drives mux_sel = i+1 (1..10). Idle code IDLE_SEL = 4'hF, which makes the mux output 0. Codes 0 and 11..14 are never driven.
- FSM states: IDLE, DRIVE.
- IDLE: wb_valid=0, mux_sel=IDLE_SEL. If any req bit is set, register the winner, load wb_src and mux_sel, set wb_valid, and go to DRIVE.
- DRIVE: mux_sel, wb_src and wb_valid are held stable while wb_ready=0. A stall counter increments each stalled cycle; at STALL_LIMIT, stall_err sets.
- Handshake (DRIVE && wb_ready && !flush):
  - gnt[wb_src]=1 combinationally in that cycle.
  - At the same edge the arbiter re-picks from req with the winner's bit masked.
  - If another source is pending, stay in DRIVE with the new winner (back-to-back, one result per cycle).
  - Otherwise return to IDLE.
- mux_sel changes between any two consecutive handshakes. The mux evaluates only on sel events, so the same source can never be driven twice without an intervening IDLE cycle; the winner mask guarantees this.
- flush has priority over everything:
  - Next state IDLE, wb_valid=0, mux_sel=IDLE_SEL, no gnt in the flush cycle.
  - Stall counter and stall_err clear; arbitration pointer is unchanged.
- req bits at index ≥ NUM_SRC do not exist; a request dropped while pending but not yet granted is protocol misuse (assertion only).
- Stall counter saturates and clears on every handshake.

## Timing
- Reset values: wb_valid=0, mux_sel=4'hF, wb_src=0, gnt=0, stall_err=0, state=IDLE, RR pointer=0, stall counter=0.
- Request latency: req rises in cycle n (in IDLE) → wb_valid/mux_sel valid in cycle n+1.
- Grant latency: gnt is asserted in the cycle wb_valid&&wb_ready; the source deasserts req or presents a new result from cycle n+1.
- Throughput: 1 result/cycle with distinct requesters; 1 result per 2 cycles from a single requester.
- Simultaneous flush and wb_ready=1: flush wins; no gnt, and the result is dropped.
- Reset mid-DRIVE: outputs return to their reset values at the next edge and no grant is issued.

## Configuration
- RESULT_ARB_RR_EN defined: round-robin arbitration.
  - The pointer advances to winner+1 (mod NUM_SRC) on each handshake.
  - Search starts at the pointer.
- RESULT_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - The pointer logic is absent.
  - Winner masking at the handshake edge still applies.

## Structure
- Shared package ex_pkg holds:
  - SEL_W=4 and IDLE_SEL=4'hF.
  - The state enum {IDLE, DRIVE}.
  - A function src_to_sel(idx) returning idx+1.
- Sub-module ex_src_pick: combinational masked priority picker. Inputs are req, mask and start pointer; outputs are a found flag and the index. Instantiated once.

## Test plan
- Single request: req=10'b0000001000 with wb_ready=1 → next cycle mux_sel=4, wb_src=3, wb_valid=1, gnt=10'b0000001000 in that cycle; then IDLE with mux_sel=F.
- Contention: req=10'b1000000011 held, wb_ready=1.
  - Fixed priority: grant order 0,1,9.
  - RR: grant order 0,1,9, then 0 again only after an IDLE gap.
  - In both modes mux_sel takes values 1,2,10.
- Back-pressure: winner 5, wb_ready=0 for 4 cycles → mux_sel=6 stable and gnt=0; handshake occurs in cycle 5.
- Stall error: STALL_LIMIT=3, wb_ready=0 for 3 cycles → stall_err=1 and sticky; flush → stall_err=0.
- Flush during handshake: DRIVE, wb_ready=1, flush=1 → gnt=0; next cycle wb_valid=0, mux_sel=F; the pending req is re-granted afterward.
- Reset mid-DRIVE: rst_n=0 for one cycle → all outputs at their reset values at the next edge.

Source files
------------

// File: rtl/ex_pkg.sv
// +----------------------------------------------------------------------+
// | ex_pkg: shared types and helpers for the EX result arbiter           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ex_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] IDLE_SEL = 4'hF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // Mux input i sits behind select code i+1; code 0 is never used.
  function automatic logic [SEL_W-1:0] src_to_sel(input logic [SEL_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_src_pick.sv
// +----------------------------------------------------------------------+
// | ex_src_pick: masked circular priority picker starting at a pointer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ex_src_pick
  import ex_pkg::*;
#(
  parameter int NUM_SRC = 10
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] mask,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_SRC-1:0] w_cand;
  int                 w_pos;

  assign w_cand = req & ~mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_pos = int'(start) + k;
      if (w_pos >= NUM_SRC) begin
        w_pos = w_pos - NUM_SRC;
      end
      if (!found && w_cand[w_pos]) begin
        found = 1'b1;
        idx   = SEL_W'(w_pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_result_arb.sv
// +----------------------------------------------------------------------+
// | ex_result_arb: shares the 10:1 EX result mux between result sources  |
// | Build option: RESULT_ARB_RR_EN selects round-robin, else fixed prio  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ex_result_arb
  import ex_pkg::*;
#(
  parameter int NUM_SRC     = 10,
  parameter int STALL_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  input  logic               flush,
  input  logic               wb_ready,
  output logic               wb_valid,
  output logic [SEL_W-1:0]   mux_sel,
  output logic [SEL_W-1:0]   wb_src,
  output logic               stall_err
);

  state_e             r_state;
  logic [7:0]         r_stall_cnt;
  logic               w_hs;
  logic [NUM_SRC-1:0] w_oh;
  logic [NUM_SRC-1:0] w_mask;
  logic [SEL_W-1:0]   w_start;
  logic [SEL_W-1:0]   w_ptr_next;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;

  assign w_hs       = (r_state == DRIVE) && wb_ready && !flush;
  assign w_oh       = NUM_SRC'(1) << wb_src;
  assign gnt        = (w_hs && rst_n) ? w_oh : '0;
  // Masking the outgoing winner keeps mux_sel moving between handshakes.
  assign w_mask     = w_hs ? w_oh : '0;
  assign w_ptr_next = (wb_src == SEL_W'(NUM_SRC - 1)) ? '0 : wb_src + 4'd1;

`ifdef RESULT_ARB_RR_EN
  logic [SEL_W-1:0] r_ptr;

  assign w_start = w_hs ? w_ptr_next : r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_next;
    end
  end
`else
  assign w_start = '0;
`endif

  ex_src_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (req),
    .mask  (w_mask),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      wb_valid    <= 1'b0;
      mux_sel     <= IDLE_SEL;
      wb_src      <= '0;
      stall_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      wb_valid    <= 1'b0;
      mux_sel     <= IDLE_SEL;
      stall_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= DRIVE;
            wb_valid    <= 1'b1;
            wb_src      <= w_idx;
            mux_sel     <= src_to_sel(w_idx);
            r_stall_cnt <= '0;
          end
        end
        DRIVE: begin
          if (wb_ready) begin
            r_stall_cnt <= '0;
            if (w_found) begin
              wb_src  <= w_idx;
              mux_sel <= src_to_sel(w_idx);
            end else begin
              r_state  <= IDLE;
              wb_valid <= 1'b0;
              mux_sel  <= IDLE_SEL;
            end
          end else begin
            if (r_stall_cnt < 8'(STALL_LIMIT)) begin
              r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (r_stall_cnt >= 8'(STALL_LIMIT - 1)) begin
              stall_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A source must hold its request until it has been granted.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_req_hold
      a_req_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (req[i] && !gnt[i]) |=> req[i]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ex_result_arb.sv
// +----------------------------------------------------------------------+
// | tb_ex_result_arb: directed and random checks against a cycle model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ex_result_arb;

  localparam int N = 10;
  localparam int L = 3;
`ifdef RESULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, flush, wb_ready;
  logic [N-1:0] req, gnt;
  logic         wb_valid, stall_err;
  logic [3:0]   mux_sel, wb_src;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_busy;
  int m_src, m_ptr, m_cnt;
  bit m_err;

  logic [N-1:0] exp_gnt, obs_gnt;
  logic [3:0]   obs_sel;

  always #5 clk = ~clk;

  ex_result_arb #(
    .NUM_SRC     (N),
    .STALL_LIMIT (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .flush     (flush),
    .wb_ready  (wb_ready),
    .wb_valid  (wb_valid),
    .mux_sel   (mux_sel),
    .wb_src    (wb_src),
    .stall_err (stall_err)
  );

  function automatic int pick(logic [N-1:0] r, int excl, int start);
    for (int k = 0; k < N; k++) begin
      int j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [9:0] exp_outs();
    return {m_busy, m_busy ? 4'(m_src + 1) : 4'hF, 4'(m_src), m_err};
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_src = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    end else if (flush) begin
      m_busy = 0; m_cnt = 0; m_err = 0;
    end else if (!m_busy) begin
      w = pick(req, -1, RR ? m_ptr : 0);
      if (w >= 0) begin m_busy = 1; m_src = w; m_cnt = 0; end
    end else if (wb_ready) begin
      if (RR) m_ptr = (m_src + 1) % N;
      m_cnt = 0;
      w = pick(req, m_src, RR ? m_ptr : 0);
      if (w >= 0) m_src = w;
      else m_busy = 0;
    end else begin
      if (m_cnt < L) m_cnt++;
      if (m_cnt >= L) m_err = 1;
    end
  endtask

  // One clock: sample combinational gnt mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk);
    exp_gnt = (rst_n && m_busy && wb_ready && !flush) ? (N'(1) << m_src) : '0;
    obs_gnt = gnt;
    obs_sel = mux_sel;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = '0; flush = 0; wb_ready = 0;
    tick();
    tick();
    checks++;
    if ({wb_valid, mux_sel, wb_src, stall_err} !== {1'b0, 4'hF, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outs got=%h want=%h", {wb_valid, mux_sel, wb_src, stall_err}, {1'b0, 4'hF, 4'h0, 1'b0});
    end
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    rst_n = 1;
  endtask

  task automatic test_single();
    req = 10'b0000001000; wb_ready = 1;
    tick();
    checks++;
    if ({wb_valid, mux_sel, wb_src} !== {1'b1, 4'h4, 4'h3}) begin
      errors++; $display("FAIL single_drive got=%h want=%h", {wb_valid, mux_sel, wb_src}, {1'b1, 4'h4, 4'h3});
    end
    tick();
    checks++;
    if (obs_gnt !== 10'b0000001000) begin
      errors++; $display("FAIL single_gnt got=%b want=%b", obs_gnt, 10'b0000001000);
    end
    req = '0;
    checks++;
    if ({wb_valid, mux_sel} !== {1'b0, 4'hF}) begin
      errors++; $display("FAIL single_idle got=%h want=%h", {wb_valid, mux_sel}, {1'b0, 4'hF});
    end
  endtask

  task automatic test_contention();
    int order[$];
    int sels[$];
    int want_o[3] = '{0, 1, 9};
    int want_s[3] = '{1, 2, 10};
    int n = 0;
    req = 10'b1000000011; wb_ready = 1;
    while ((req != '0 || m_busy) && n < 12) begin
      tick();
      n++;
      checks++;
      if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL cont_gnt got=%b want=%b", obs_gnt, exp_gnt); end
      if (obs_gnt != '0) begin order.push_back(oh_idx(obs_gnt)); sels.push_back(int'(obs_sel)); end
      req = req & ~exp_gnt;
    end
    checks++;
    if (order.size() != 3) begin
      errors++; $display("FAIL cont_count got=%0d want=3", order.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (order[i] != want_o[i] || sels[i] != want_s[i]) begin
          errors++; $display("FAIL cont_order[%0d] got=%0d/sel%0d want=%0d/sel%0d", i, order[i], sels[i], want_o[i], want_s[i]);
        end
      end
    end
    // source 0 again: it only comes back through IDLE
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL cont_gap got=%b want=0", wb_valid); end
    req = 10'b0000000001;
    tick();
    tick();
    checks++;
    if (obs_gnt !== 10'b0000000001) begin errors++; $display("FAIL cont_regrant got=%b want=1", obs_gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    req = 10'b0000100000; wb_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_gnt !== '0 || mux_sel !== 4'h6 || wb_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] gnt=%b sel=%h valid=%b want gnt=0 sel=6 valid=1", i, obs_gnt, mux_sel, wb_valid);
      end
    end
    wb_ready = 1;
    tick();
    checks++;
    if (obs_gnt !== 10'b0000100000) begin errors++; $display("FAIL bp_gnt got=%b want=%b", obs_gnt, 10'b0000100000); end
    req = '0;
    checks++;
    if (stall_err !== 1'b1) begin errors++; $display("FAIL stall_sticky got=%b want=1", stall_err); end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (stall_err !== 1'b0) begin errors++; $display("FAIL stall_flush got=%b want=0", stall_err); end
  endtask

  task automatic test_flush_hs();
    req = 10'b0000000100; wb_ready = 1;
    tick();
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (obs_gnt !== '0 || wb_valid !== 1'b0 || mux_sel !== 4'hF) begin
      errors++; $display("FAIL flush_hs gnt=%b valid=%b sel=%h want gnt=0 valid=0 sel=F", obs_gnt, wb_valid, mux_sel);
    end
    tick();
    tick();
    checks++;
    if (obs_gnt !== 10'b0000000100) begin errors++; $display("FAIL flush_regrant got=%b want=%b", obs_gnt, 10'b0000000100); end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 10'b0010000000; wb_ready = 0;
    tick();
    wb_ready = 1; rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (obs_gnt !== '0 || {wb_valid, mux_sel, wb_src, stall_err} !== {1'b0, 4'hF, 4'h0, 1'b0}) begin
      errors++; $display("FAIL reset_mid gnt=%b outs=%h want gnt=0 outs=%h", obs_gnt, {wb_valid, mux_sel, wb_src, stall_err}, {1'b0, 4'hF, 4'h0, 1'b0});
    end
    tick();
    tick();
    checks++;
    if (obs_gnt !== 10'b0010000000) begin errors++; $display("FAIL reset_regrant got=%b want=%b", obs_gnt, 10'b0010000000); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    int n = 0;
    bit prev_hs = 0;
    logic [3:0] prev_sel = 4'hF;
    for (int c = 0; c < 400; c++) begin
      flush    = ($urandom_range(0, 19) == 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, obs_gnt, exp_gnt); end
      checks++;
      if ({wb_valid, mux_sel, wb_src, stall_err} !== exp_outs()) begin
        errors++; $display("FAIL rnd_outs c=%0d got=%h want=%h", c, {wb_valid, mux_sel, wb_src, stall_err}, exp_outs());
      end
      if (exp_gnt != '0) begin
        if (prev_hs) begin
          checks++;
          if (obs_sel === prev_sel) begin errors++; $display("FAIL rnd_sel_change c=%0d got=%h want!=%h", c, obs_sel, prev_sel); end
        end
        prev_sel = obs_sel;
      end
      prev_hs = (exp_gnt != '0);
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
      end
    end
    flush = 0; wb_ready = 1;
    while ((req != '0 || m_busy) && n < 60) begin
      tick();
      n++;
      checks++;
      if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL drain_gnt got=%b want=%b", obs_gnt, exp_gnt); end
      req = req & ~exp_gnt;
    end
    checks++;
    if (m_busy || wb_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout valid=%b want=0", wb_valid); end
  endtask

  initial begin
    rst_n = 0; req = '0; flush = 0; wb_ready = 0;
    m_busy = 0; m_src = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush_hs();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
